traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_pkg.sv | 66 ++++++
 rtl/lamp_decode.sv | 33 +++
 rtl/traffic_light_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic light types: phase encodings, fault codes, dwell defaults.
// Used by the controller and by the lamp monitor.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_PAUSE   = 3'd0,
    PH_NS_OK   = 3'd1,
    PH_NS_WARN = 3'd2,
    PH_EW_OK   = 3'd3,
    PH_EW_WARN = 3'd4,
    PH_ILLEGAL = 3'd7
  } phase_t;

  typedef enum logic [2:0] {
    FLT_NONE  = 3'd0,
    FLT_LAMPS = 3'd1,
    FLT_TRANS = 3'd2,
    FLT_SHORT = 3'd3,
    FLT_LONG  = 3'd4,
    FLT_DIR   = 3'd5
  } fault_t;

  // Hunt = not yet synced; suffix is the last green direction.
  typedef enum logic [1:0] {
    MON_HUNT_NS = 2'd0,
    MON_HUNT_EW = 2'd1,
    MON_SYNC_NS = 2'd2,
    MON_SYNC_EW = 2'd3
  } mon_state_t;

  localparam int DEF_OK_SEC    = 20;
  localparam int DEF_WARN_SEC  = 5;
  localparam int DEF_PAUSE_SEC = 2;

  localparam int DWELL_W = 6;
  localparam logic [DWELL_W-1:0] DWELL_MAX = 6'd63;

  // Lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  localparam logic [5:0] LAMP_PAUSE   = 6'b100_100;
  localparam logic [5:0] LAMP_NS_OK   = 6'b001_100;
  localparam logic [5:0] LAMP_NS_WARN = 6'b010_100;
  localparam logic [5:0] LAMP_EW_OK   = 6'b100_001;
  localparam logic [5:0] LAMP_EW_WARN = 6'b100_010;

  function automatic logic is_ew(input phase_t p);
    return (p == PH_EW_OK) || (p == PH_EW_WARN);
  endfunction

  function automatic logic legal_step(
    input phase_t from,
    input phase_t to
  );
    logic ok;
    ok = 1'b0;
    case (from)
      PH_PAUSE:   ok = (to == PH_NS_OK) || (to == PH_EW_OK);
      PH_NS_OK:   ok = (to == PH_NS_WARN);
      PH_NS_WARN: ok = (to == PH_PAUSE);
      PH_EW_OK:   ok = (to == PH_EW_WARN);
      PH_EW_WARN: ok = (to == PH_PAUSE);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Maps six observed lamp drives onto a traffic phase.
// Anything outside the five legal patterns decodes as ILLEGAL.
module lamp_decode
  import traffic_pkg::*;
(
  input  logic   ns_red,
  input  logic   ns_yellow,
  input  logic   ns_green,
  input  logic   ew_red,
  input  logic   ew_yellow,
  input  logic   ew_green,
  output phase_t phase
);

  logic [5:0] lamps;

  assign lamps = {ns_red, ns_yellow, ns_green,
                  ew_red, ew_yellow, ew_green};

  // Exact pattern match; patterns are mutually exclusive
  always_comb begin
    phase = PH_ILLEGAL;
    unique case (1'b1)
      (lamps == LAMP_PAUSE):   phase = PH_PAUSE;
      (lamps == LAMP_NS_OK):   phase = PH_NS_OK;
      (lamps == LAMP_NS_WARN): phase = PH_NS_WARN;
      (lamps == LAMP_EW_OK):   phase = PH_EW_OK;
      (lamps == LAMP_EW_WARN): phase = PH_EW_WARN;
      default:                 phase = PH_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches lamp drives and checks phase order, dwell and alternation.
// Latches the first fault; counts completed NS green entries.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int OK_SEC    = DEF_OK_SEC,
  parameter int WARN_SEC  = DEF_WARN_SEC,
  parameter int PAUSE_SEC = DEF_PAUSE_SEC
) (
  input  logic        CLK,
  input  logic        RS,
  input  logic        TICK,
  input  logic        CLR,
  input  logic        NS_RED,
  input  logic        NS_YELLOW,
  input  logic        NS_GREEN,
  input  logic        EW_RED,
  input  logic        EW_YELLOW,
  input  logic        EW_GREEN,
  output logic [2:0]  PHASE,
  output logic        SYNCED,
  output logic        FAULT,
  output logic [2:0]  FAULT_CODE,
  output logic [15:0] CYCLE_CNT
);

  logic [5:0]         lamps_q;
  phase_t             phase;
  phase_t             phase_prev;
  logic               lamp_vld;
  logic               prev_vld;
  logic               change;
  mon_state_t         state_q;
  mon_state_t         state_n;
  logic               synced;
  logic               last_ew;
  logic               new_sync;
  logic               new_ew;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_n;
  int                 dwell_i;
  int                 req_prev;
  int                 req_cur;
  fault_t             det;
  logic               fault_q;
  fault_t             code_q;
  logic [15:0]        cyc_q;
  logic               ns_cycle;

  function automatic int req_sec(input phase_t p);
    int s;
    s = 0;
    case (p)
      PH_PAUSE:   s = PAUSE_SEC;
      PH_NS_OK:   s = OK_SEC;
      PH_EW_OK:   s = OK_SEC;
      PH_NS_WARN: s = WARN_SEC;
      PH_EW_WARN: s = WARN_SEC;
      default:    s = 0;
    endcase
    return s;
  endfunction

  lamp_decode u_dec (
    .ns_red    (lamps_q[5]),
    .ns_yellow (lamps_q[4]),
    .ns_green  (lamps_q[3]),
    .ew_red    (lamps_q[2]),
    .ew_yellow (lamps_q[1]),
    .ew_green  (lamps_q[0]),
    .phase     (phase)
  );

  // Register lamps and previous phase; warm-up hides the reset image
  always_ff @(posedge CLK or posedge RS) begin
    if (RS) begin
      lamps_q    <= LAMP_PAUSE;
      phase_prev <= PH_PAUSE;
      lamp_vld   <= 1'b0;
      prev_vld   <= 1'b0;
    end else begin
      lamps_q    <= {NS_RED, NS_YELLOW, NS_GREEN,
                     EW_RED, EW_YELLOW, EW_GREEN};
      phase_prev <= phase;
      lamp_vld   <= 1'b1;
      prev_vld   <= lamp_vld;
    end
  end

  assign change  = prev_vld && (phase != phase_prev);
  assign synced  = (state_q == MON_SYNC_NS) ||
                   (state_q == MON_SYNC_EW);
  assign last_ew = (state_q == MON_HUNT_EW) ||
                   (state_q == MON_SYNC_EW);

  // Monitor state register: sync flag plus last direction
  always_ff @(posedge CLK or posedge RS) begin
    if (RS) state_q <= MON_HUNT_NS;
    else    state_q <= state_n;
  end

  // Next state; the sync change infers direction from its phases
  always_comb begin
    state_n  = state_q;
    new_sync = synced;
    new_ew   = last_ew;
    if (change && !synced &&
        phase != PH_ILLEGAL && phase_prev != PH_ILLEGAL) begin
      new_sync = 1'b1;
      new_ew   = (phase == PH_PAUSE) ? is_ew(phase_prev)
                                     : is_ew(phase);
    end else if (change &&
                 (phase == PH_NS_OK || phase == PH_EW_OK)) begin
      new_ew = is_ew(phase);
    end
    if (CLR) begin
      state_n = MON_HUNT_NS;
    end else begin
      case ({new_sync, new_ew})
        2'b00:   state_n = MON_HUNT_NS;
        2'b01:   state_n = MON_HUNT_EW;
        2'b10:   state_n = MON_SYNC_NS;
        default: state_n = MON_SYNC_EW;
      endcase
    end
  end

  // Dwell seconds in the current phase; entry tick counts here
  always_comb begin
    dwell_n = dwell_q;
    if (change)
      dwell_n = {{(DWELL_W-1){1'b0}}, TICK};
    else if (TICK && dwell_q != DWELL_MAX)
      dwell_n = dwell_q + 1'b1;
  end

  // Dwell register
  always_ff @(posedge CLK or posedge RS) begin
    if (RS)       dwell_q <= '0;
    else if (CLR) dwell_q <= '0;
    else          dwell_q <= dwell_n;
  end

  // Fault detection; lowest code wins when several coincide
  always_comb begin
    det      = FLT_NONE;
    dwell_i  = {{(32-DWELL_W){1'b0}}, dwell_q};
    req_prev = req_sec(phase_prev);
    req_cur  = req_sec(phase);
    if (phase == PH_ILLEGAL) begin
      det = FLT_LAMPS;
    end else if (synced && change &&
                 !legal_step(phase_prev, phase)) begin
      det = FLT_TRANS;
    end else if (synced && change &&
                 phase_prev != PH_ILLEGAL &&
                 dwell_i < req_prev - 1) begin
      det = FLT_SHORT;
    end else if (synced && !change &&
                 dwell_i >= req_cur + 1) begin
      det = FLT_LONG;
    end else if (synced && change &&
                 phase_prev == PH_PAUSE &&
                 is_ew(phase) == last_ew) begin
      det = FLT_DIR;
    end
  end

  // Sticky fault flag with first-fault code; CLR wins
  always_ff @(posedge CLK or posedge RS) begin
    if (RS) begin
      fault_q <= 1'b0;
      code_q  <= FLT_NONE;
    end else if (CLR) begin
      fault_q <= 1'b0;
      code_q  <= FLT_NONE;
    end else if (det != FLT_NONE) begin
      fault_q <= 1'b1;
      if (!fault_q) code_q <= det;
    end
  end

  assign ns_cycle = synced && change &&
                    phase_prev == PH_PAUSE &&
                    phase == PH_NS_OK;

  // Completed-cycle counter, survives CLR, saturates
  always_ff @(posedge CLK or posedge RS) begin
    if (RS)
      cyc_q <= '0;
    else if (ns_cycle && cyc_q != 16'hFFFF)
      cyc_q <= cyc_q + 16'd1;
  end

  assign PHASE      = phase;
  assign SYNCED     = synced;
  assign FAULT      = fault_q;
  assign FAULT_CODE = code_q;
  assign CYCLE_CNT  = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor.
// One second = 4 clocks, tick on the last clock.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  logic        CLK = 1'b0;
  logic        RS;
  logic        TICK;
  logic        CLR;
  logic [5:0]  lamps;
  logic [2:0]  PHASE;
  logic        SYNCED;
  logic        FAULT;
  logic [2:0]  FAULT_CODE;
  logic [15:0] CYCLE_CNT;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [5:0] LAMP_BAD = 6'b001_001;

  traffic_light_monitor #(
    .OK_SEC    (4),
    .WARN_SEC  (2),
    .PAUSE_SEC (1)
  ) dut (
    .CLK        (CLK),
    .RS         (RS),
    .TICK       (TICK),
    .CLR        (CLR),
    .NS_RED     (lamps[5]),
    .NS_YELLOW  (lamps[4]),
    .NS_GREEN   (lamps[3]),
    .EW_RED     (lamps[2]),
    .EW_YELLOW  (lamps[1]),
    .EW_GREEN   (lamps[0]),
    .PHASE      (PHASE),
    .SYNCED     (SYNCED),
    .FAULT      (FAULT),
    .FAULT_CODE (FAULT_CODE),
    .CYCLE_CNT  (CYCLE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sec(input int n);
    for (int i = 0; i < n; i++) begin
      TICK = 1'b0;
      step();
      step();
      step();
      TICK = 1'b1;
      step();
      TICK = 1'b0;
    end
  endtask

  task automatic hold(input logic [5:0] l, input int n);
    lamps = l;
    sec(n);
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  task automatic full_cycle();
    hold(LAMP_NS_OK, 4);
    hold(LAMP_NS_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_EW_OK, 4);
    hold(LAMP_EW_WARN, 2);
    hold(LAMP_PAUSE, 1);
  endtask

  initial begin
    RS    = 1'b1;
    TICK  = 1'b0;
    CLR   = 1'b0;
    lamps = LAMP_PAUSE;
    step();
    step();
    check("rst_phase", 16'(PHASE), 16'd0);
    check("rst_sync", 16'(SYNCED), 16'd0);
    check("rst_fault", 16'(FAULT), 16'd0);
    check("rst_code", 16'(FAULT_CODE), 16'd0);
    check("rst_cnt", CYCLE_CNT, 16'd0);
    RS = 1'b0;
    step();

    // correct sequence, three full cycles
    hold(LAMP_PAUSE, 1);
    hold(LAMP_NS_OK, 4);
    check("seq_phase", 16'(PHASE), 16'd1);
    check("seq_sync", 16'(SYNCED), 16'd1);
    hold(LAMP_NS_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_EW_OK, 4);
    hold(LAMP_EW_WARN, 2);
    hold(LAMP_PAUSE, 1);
    full_cycle();
    full_cycle();
    check("seq_fault", 16'(FAULT), 16'd0);
    check("seq_cnt2", CYCLE_CNT, 16'd2);
    hold(LAMP_NS_OK, 1);
    check("seq_cnt3", CYCLE_CNT, 16'd3);
    check("seq_code", 16'(FAULT_CODE), 16'd0);

    // illegal lamps for one cycle
    lamps = LAMP_BAD;
    step();
    lamps = LAMP_NS_OK;
    check("ill_phase", 16'(PHASE), 16'd7);
    check("ill_early", 16'(FAULT), 16'd0);
    step();
    check("ill_fault", 16'(FAULT), 16'd1);
    check("ill_code", 16'(FAULT_CODE), 16'd1);
    sec(1);
    check("ill_code_kept", 16'(FAULT_CODE), 16'd1);
    clr_pulse();
    check("clr_fault", 16'(FAULT), 16'd0);
    check("clr_code", 16'(FAULT_CODE), 16'd0);
    check("clr_sync", 16'(SYNCED), 16'd0);
    check("clr_cnt", CYCLE_CNT, 16'd3);

    // NS_OK held too long
    hold(LAMP_NS_WARN, 2);
    check("resync", 16'(SYNCED), 16'd1);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_EW_OK, 4);
    hold(LAMP_EW_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_NS_OK, 4);
    check("long_4tick", 16'(FAULT), 16'd0);
    sec(1);
    check("long_5tick", 16'(FAULT), 16'd0);
    step();
    check("long_fault", 16'(FAULT), 16'd1);
    check("long_code", 16'(FAULT_CODE), 16'd4);
    sec(1);
    check("long_sync", 16'(SYNCED), 16'd1);
    clr_pulse();

    // NS_OK left too early
    hold(LAMP_NS_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_EW_OK, 4);
    hold(LAMP_EW_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_NS_OK, 2);
    lamps = LAMP_NS_WARN;
    step();
    step();
    check("short_code", 16'(FAULT_CODE), 16'd3);
    sec(2);
    clr_pulse();

    // same direction twice
    hold(LAMP_PAUSE, 1);
    hold(LAMP_EW_OK, 3);
    hold(LAMP_EW_WARN, 2);
    check("min_dwell_ok", 16'(FAULT), 16'd0);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_NS_OK, 4);
    hold(LAMP_NS_WARN, 2);
    hold(LAMP_PAUSE, 1);
    check("dir_pre", 16'(FAULT), 16'd0);
    lamps = LAMP_NS_OK;
    step();
    step();
    check("dir_code", 16'(FAULT_CODE), 16'd5);
    clr_pulse();

    // green to green
    hold(LAMP_NS_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_EW_OK, 4);
    hold(LAMP_EW_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_NS_OK, 4);
    lamps = LAMP_EW_OK;
    step();
    step();
    check("trans_code", 16'(FAULT_CODE), 16'd2);
    check("trans_sync", 16'(SYNCED), 16'd1);
    clr_pulse();

    // CLR coincides with an illegal transition
    hold(LAMP_EW_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_NS_OK, 4);
    check("pre_clr_sync", 16'(SYNCED), 16'd1);
    lamps = LAMP_EW_OK;
    step();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("clrw_fault", 16'(FAULT), 16'd0);
    check("clrw_sync", 16'(SYNCED), 16'd0);
    step();
    check("clrw_fault2", 16'(FAULT), 16'd0);
    check("clrw_code", 16'(FAULT_CODE), 16'd0);

    // async reset in the middle of EW_OK
    hold(LAMP_EW_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_NS_OK, 4);
    hold(LAMP_NS_WARN, 2);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_EW_OK, 2);
    RS = 1'b1;
    #2;
    check("rs_phase", 16'(PHASE), 16'd0);
    check("rs_sync", 16'(SYNCED), 16'd0);
    check("rs_fault", 16'(FAULT), 16'd0);
    check("rs_code", 16'(FAULT_CODE), 16'd0);
    check("rs_cnt", CYCLE_CNT, 16'd0);
    step();
    RS = 1'b0;
    sec(2);
    check("rs_unsync", 16'(SYNCED), 16'd0);
    check("rs_partial", 16'(FAULT), 16'd0);
    hold(LAMP_EW_WARN, 2);
    check("rs_resync", 16'(SYNCED), 16'd1);
    hold(LAMP_PAUSE, 1);
    hold(LAMP_NS_OK, 4);
    check("rs_nofault", 16'(FAULT), 16'd0);
    check("rs_code2", 16'(FAULT_CODE), 16'd0);
    check("rs_cnt1", CYCLE_CNT, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
